rf_writeback: RTL

//  Write-side master for the 32x32 register file: merges ALU and load-unit results onto the single
//  we/rd_addr/rd_data write port. Tracks loads in flight with a pending-register scoreboard for

---
 rtl/rf_pkg.sv | 27 ++
 rtl/rf_wb_fifo.sv | 54 +++++
 rtl/rf_writeback.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Package rf_pkg: shared widths and the write-back request type used by the
// register-file write-side logic (rf_writeback and its load-result FIFO).
package rf_pkg;

  localparam int XLEN   = 32;  // data width
  localparam int REG_AW = 5;   // register address width
  localparam int NREGS  = 32;  // number of architectural registers

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // One-hot mask for a register index; x0 never produces a bit.
  function automatic logic [NREGS-1:0] reg_mask(input logic [REG_AW-1:0] r);
    logic [NREGS-1:0] m;
    m = {NREGS{1'b0}};
    if (r != {REG_AW{1'b0}}) begin
      m[r] = 1'b1;
    end else begin
      m = {NREGS{1'b0}};
    end
    return m;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: synchronous FIFO of wb_req_t used to queue load results.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset (empties the FIFO)
//   push, din    write one entry (caller guarantees !full)
//   pop          discard the head entry (caller guarantees !empty)
//   head         current head entry (valid while !empty)
//   full, empty  occupancy flags, derived from registered pointers only
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  wb_req_t     mem_r [DEPTH];

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head  = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update and storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: write-side master for the 32x32 register file. Merges ALU and
// load results onto one registered write port, tracks loads in flight in a
// pending-register scoreboard, and flags loads issued to already-pending regs.
// Ports:
//   clk, rst_n                  clock / asynchronous active-low reset
//   alu_valid/ready/rd/data     ALU result handshake (ready = not forcing LSU)
//   lsu_valid/ready/rd/data     load result handshake (ready = FIFO not full)
//   iss_valid, iss_rd           load issue notification for the scoreboard
//   pend                        per-register "load in flight" bits (bit 0 = 0)
//   sb_err                      sticky: load issued to an already-pending reg
//   rf_we, rf_rd_addr, rf_rd_data  registered register-file write port
// Optional feature macro RF_WB_BYPASS_EN: adds byp_valid/byp_rd/byp_data, a
// combinational view of this cycle's winner, one cycle ahead of rf_we.
module rf_writeback
  import rf_pkg::*;
#(
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  output logic [NREGS-1:0]  pend,
`ifdef RF_WB_BYPASS_EN
  output logic              byp_valid,
  output logic [REG_AW-1:0] byp_rd,
  output logic [XLEN-1:0]   byp_data,
`endif
  output logic              sb_err,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd_addr,
  output logic [XLEN-1:0]   rf_rd_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic             fifo_full_s;
  logic             fifo_empty_s;
  wb_req_t          fifo_head_s;
  wb_req_t          lsu_req_s;
  logic             push_s;
  logic             pop_s;
  logic             alu_fire_s;
  logic             force_lsu_s;
  logic             win_valid_s;
  wb_req_t          win_s;
  logic             win_we_s;
  logic [CW-1:0]    starve_cnt_r;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;
  logic             sb_hit_s;
  logic [NREGS-1:0] pend_r;
  logic             sb_err_r;
  logic             rf_we_r;
  logic [REG_AW-1:0] rf_rd_addr_r;
  logic [XLEN-1:0]  rf_rd_data_r;

  // Both readies depend only on registered state, never on the valids.
  assign force_lsu_s = (starve_cnt_r == CW'(STARVE_MAX));
  assign alu_ready   = !force_lsu_s;
  assign lsu_ready   = !fifo_full_s;
  assign alu_fire_s  = alu_valid && !force_lsu_s;
  assign push_s      = lsu_valid && !fifo_full_s;
  assign lsu_req_s   = '{rd: lsu_rd, data: lsu_data};

  rf_wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (lsu_req_s),
    .pop   (pop_s),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Arbitration: a forced or uncontested load pops; otherwise the ALU wins.
  always_comb begin
    pop_s       = !fifo_empty_s && (force_lsu_s || !alu_fire_s);
    win_valid_s = 1'b0;
    win_s       = '0;
    if (pop_s) begin
      win_valid_s = 1'b1;
      win_s       = fifo_head_s;
    end else if (alu_fire_s) begin
      win_valid_s = 1'b1;
      win_s       = '{rd: alu_rd, data: alu_data};
    end else begin
      win_valid_s = 1'b0;
      win_s       = '0;
    end
  end

  // x0 writes are dropped at the port but still count as a winner.
  assign win_we_s = win_valid_s && (win_s.rd != {REG_AW{1'b0}});

  // Scoreboard masks; a popped load clears its own register.
  always_comb begin
    set_mask_s = {NREGS{1'b0}};
    clr_mask_s = {NREGS{1'b0}};
    if (iss_valid) begin
      set_mask_s = reg_mask(iss_rd);
    end else begin
      set_mask_s = {NREGS{1'b0}};
    end
    if (pop_s) begin
      clr_mask_s = reg_mask(fifo_head_s.rd);
    end else begin
      clr_mask_s = {NREGS{1'b0}};
    end
  end

  // A re-issue is only an error when the earlier load is not retiring now.
  assign sb_hit_s = |(set_mask_s & pend_r & ~clr_mask_s);

  // Starvation counter: counts ALU wins over a waiting load, cleared by any pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {CW{1'b0}};
    end else if (pop_s) begin
      starve_cnt_r <= {CW{1'b0}};
    end else if (!fifo_empty_s && alu_fire_s) begin
      starve_cnt_r <= starve_cnt_r + CW'(1);
    end
  end

  // Scoreboard state; set wins over a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r   <= {NREGS{1'b0}};
      sb_err_r <= 1'b0;
    end else begin
      pend_r <= (pend_r & ~clr_mask_s) | set_mask_s;
      if (sb_hit_s) begin
        sb_err_r <= 1'b1;
      end
    end
  end

  // Register-file write port, one cycle after arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r      <= 1'b0;
      rf_rd_addr_r <= {REG_AW{1'b0}};
      rf_rd_data_r <= {XLEN{1'b0}};
    end else begin
      rf_we_r <= win_we_s;
      if (win_valid_s) begin
        rf_rd_addr_r <= win_s.rd;
        rf_rd_data_r <= win_s.data;
      end
    end
  end

  assign pend       = pend_r;
  assign sb_err     = sb_err_r;
  assign rf_we      = rf_we_r;
  assign rf_rd_addr = rf_rd_addr_r;
  assign rf_rd_data = rf_rd_data_r;

`ifdef RF_WB_BYPASS_EN
  assign byp_valid = win_we_s;
  assign byp_rd    = win_s.rd;
  assign byp_data  = win_s.data;
`endif

endmodule
